// File: rtl/demux_l2_sched_pkg.sv
// Shared encodings for the level-2 demux scheduler: FSM states, routing modes
// and demux select values.
package demux_l2_sched_pkg;

  typedef enum logic [1:0] {
    ST_INIT    = 2'd0,
    ST_IDLE    = 2'd1,
    ST_ACTIVE  = 2'd2,
    ST_BLOCKED = 2'd3
  } state_t;

  localparam logic MODE_RR    = 1'b0;
  localparam logic MODE_CLASS = 1'b1;

  localparam logic SEL_B = 1'b0;
  localparam logic SEL_C = 1'b1;

endpackage

// File: rtl/demux_l2_sched_arb2.sv
// Combinational 2-way arbiter: picks the destination branch for the head word
// and reports whether that branch can take it.
module sched_arb2
  import demux_l2_sched_pkg::*;
(
  input  logic mode_reg,
  input  logic rr_ptr,
  input  logic class_bit,
  input  logic almost_full_B,
  input  logic almost_full_C,
  output logic grant,
  output logic dest
);

  logic af_ptr_s;
  logic af_alt_s;

  // Back-pressure seen by the round-robin favourite and by the other branch
  always_comb begin
    af_ptr_s = 1'b0;
    af_alt_s = 1'b0;
    if (rr_ptr == SEL_C) begin
      af_ptr_s = almost_full_C;
      af_alt_s = almost_full_B;
    end else begin
      af_ptr_s = almost_full_B;
      af_alt_s = almost_full_C;
    end
  end

  // Class mode never falls back to the other branch, so the head word can block
  always_comb begin
    grant = 1'b0;
    dest  = SEL_B;
    if (mode_reg == MODE_CLASS) begin
      dest  = class_bit;
      grant = (class_bit == SEL_C) ? ~almost_full_C : ~almost_full_B;
    end else if (!af_ptr_s) begin
      dest  = rr_ptr;
      grant = 1'b1;
    end else if (!af_alt_s) begin
      dest  = ~rr_ptr;
      grant = 1'b1;
    end else begin
      dest  = rr_ptr;
      grant = 1'b0;
    end
  end

endmodule

// File: rtl/demux_l2_sched.sv
// Level-2 1:2 demux scheduler: pops FIFO A, registers word/valid/select for the
// demux, honours B/C almost_full and tracks per-branch sent counts.
module demux_l2_sched
  import demux_l2_sched_pkg::*;
#(
  parameter int BW = 8,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          init,
  input  logic          mode_in,
  input  logic [BW-1:0] data_in_A,
  input  logic          fifo_empty_A,
  input  logic          almost_full_B,
  input  logic          almost_full_C,
  output logic          pop_A,
  output logic [BW-1:0] out_data,
  output logic          valid_out,
  output logic          select_L2,
  output logic [1:0]    state,
  output logic          idle,
  output logic [CW-1:0] sent_B,
  output logic [CW-1:0] sent_C
);

  state_t        state_r;
  state_t        state_nx_s;
  logic          mode_r;
  logic          rr_ptr_r;
  logic          valid_r;
  logic          sel_r;
  logic          idle_r;
  logic [BW-1:0] data_r;
  logic [CW-1:0] sent_b_r;
  logic [CW-1:0] sent_c_r;
  logic          grant_s;
  logic          dest_s;
  logic          pop_s;

  sched_arb2 u_arb (
    .mode_reg      (mode_r),
    .rr_ptr        (rr_ptr_r),
    .class_bit     (data_in_A[BW-1]),
    .almost_full_B (almost_full_B),
    .almost_full_C (almost_full_C),
    .grant         (grant_s),
    .dest          (dest_s)
  );

  // A pop needs an operational state, no pending init, a head word and a grant
  always_comb begin
    pop_s = 1'b0;
    if ((state_r != ST_INIT) && !init && !fifo_empty_A) begin
      pop_s = grant_s;
    end else begin
      pop_s = 1'b0;
    end
  end

  // Next-state decode
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_INIT: begin
        state_nx_s = init ? ST_INIT : ST_IDLE;
      end
      ST_IDLE, ST_ACTIVE, ST_BLOCKED: begin
        if (init)              state_nx_s = ST_INIT;
        else if (fifo_empty_A) state_nx_s = ST_IDLE;
        else if (pop_s)        state_nx_s = ST_ACTIVE;
        else                   state_nx_s = ST_BLOCKED;
      end
      default: begin
        state_nx_s = ST_INIT;
      end
    endcase
  end

  // State register plus registered idle flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_INIT;
      idle_r  <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      idle_r  <= (state_nx_s == ST_IDLE);
    end
  end

  // Output register, round-robin pointer, mode latch and sent counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_r   <= MODE_RR;
      rr_ptr_r <= SEL_B;
      valid_r  <= 1'b0;
      sel_r    <= SEL_B;
      data_r   <= {BW{1'b0}};
      sent_b_r <= {CW{1'b0}};
      sent_c_r <= {CW{1'b0}};
    end else if (state_r == ST_INIT) begin
      mode_r   <= mode_in;
      rr_ptr_r <= SEL_B;
      valid_r  <= 1'b0;
      sent_b_r <= {CW{1'b0}};
      sent_c_r <= {CW{1'b0}};
    end else begin
      valid_r <= pop_s;
      if (pop_s) begin
        data_r <= data_in_A;
        sel_r  <= dest_s;
        if (dest_s == SEL_C) sent_c_r <= sent_c_r + CW'(1);
        else                 sent_b_r <= sent_b_r + CW'(1);
        if (mode_r == MODE_RR) rr_ptr_r <= ~dest_s;
      end
    end
  end

  assign pop_A     = pop_s;
  assign out_data  = data_r;
  assign valid_out = valid_r;
  assign select_L2 = sel_r;
  assign state     = state_r;
  assign idle      = idle_r;
  assign sent_B    = sent_b_r;
  assign sent_C    = sent_c_r;

endmodule
